// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage sequencer: funct3 access sizes,
// the load marker on ResultSrc, the FSM state type and the fault predicate.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RS_LOAD = 2'b01;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    // True for encodings no load or store may use, or an address not aligned to the size.
    function automatic logic access_bad(logic store, logic [2:0] f3, logic [1:0] off);
        logic illegal_f3;
        logic misaligned;
        illegal_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (store && f3[2]);
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return illegal_f3 || misaligned;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request bus between the memory-stage sequencer (master) and memory (slave).
// Handshake: a request is held with mem_addr/mem_we/mem_wdata/mem_wstrb stable while
// mem_req=1; it completes on the first cycle with mem_req=1 and mem_ready=1.
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: strobes and lane replication for stores,
// lane extraction with sign/zero extension for loads.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wstrb = 4'b0000;
        wdata = st_data;
        if (store) begin
            case (st_funct3)
                F3_SB: begin
                    wstrb = 4'b0001 << st_off;
                    wdata = {4{st_data[7:0]}};
                end
                F3_SH: begin
                    wstrb = st_off[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{st_data[15:0]}};
                end
                F3_SW:   wstrb = 4'b1111;
                default: wstrb = 4'b0000;
            endcase
        end
    end

    always_comb begin
        case (ld_off)
            2'd0:    byte_sel = ld_word[7:0];
            2'd1:    byte_sel = ld_word[15:8];
            2'd2:    byte_sel = ld_word[23:16];
            default: byte_sel = ld_word[31:24];
        endcase
        half_sel = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  ld_data = {24'h0, byte_sel};
            F3_LHU:  ld_data = {16'h0, half_sel};
            F3_LW:   ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access sequencer: issues one data-memory request per M-stage
// load/store, stalls the pipeline while it is outstanding, flags faults and timeouts.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        funct3M,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    mem_stage_ctrl_if.master  bus,
    output logic              StallMem,
    output logic [31:0]       ReadDataM,
    output logic              MemFaultM,
    output state_t            dbg_state
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;

    logic        store;
    logic        acc;
    logic        bad;
    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_wdata;
    logic [31:0] ld_data;

    // A store flag wins over a simultaneous load marker.
    assign store = MemWriteM;
    assign acc   = MemWriteM || (ResultSrcM == RS_LOAD);
    assign bad   = acc && access_bad(store, funct3M, ALUResultM[1:0]);

    assign StallMem  = ((state == IDLE) && acc && !bad) || (state == BUSY);
    assign ReadDataM = (state == DONE) ? ld_data : 32'h0;
    assign dbg_state = state;

    mem_lane_fmt u_fmt (
        .store     (store),
        .st_funct3 (funct3M),
        .st_off    (ALUResultM[1:0]),
        .st_data   (WriteDataM),
        .wstrb     (fmt_wstrb),
        .wdata     (fmt_wdata),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_word   (rdata_q),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            rdata_q       <= 32'h0;
            MemFaultM     <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_wstrb <= 4'b0000;
        end else begin
            MemFaultM <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc && bad) begin
                        MemFaultM <= 1'b1;
                    end else if (acc) begin
                        state         <= BUSY;
                        wait_cnt      <= 8'd1;
                        f3_q          <= funct3M;
                        off_q         <= ALUResultM[1:0];
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= store;
                        bus.mem_addr  <= {ALUResultM[31:2], 2'b00};
                        bus.mem_wdata <= fmt_wdata;
                        bus.mem_wstrb <= fmt_wstrb;
                    end
                end
                BUSY: begin
                    // Completion on the last allowed cycle beats the timeout.
                    if (bus.mem_ready) begin
                        rdata_q     <= bus.mem_rdata;
                        bus.mem_req <= 1'b0;
                        state       <= DONE;
                    end else if (wait_cnt == MAX_WAIT_C) begin
                        rdata_q     <= 32'h0;
                        bus.mem_req <= 1'b0;
                        MemFaultM   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    wait_cnt <= 8'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with MAX_WAIT = 4: formatting, stall length,
// alignment/illegal faults, timeout, and reset in the middle of an access.
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallMem;
    logic [31:0] ReadDataM;
    logic        MemFaultM;
    state_t      dbg_state;

    int errors = 0;
    int checks = 0;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .bus        (bus),
        .StallMem   (StallMem),
        .ReadDataM  (ReadDataM),
        .MemFaultM  (MemFaultM),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemWriteM  = we;
        ResultSrcM = rs;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    endtask

    // One good access starting at a negedge in IDLE; memory answers after extra_waits stalls.
    task automatic access(input string tag, input logic we, input logic [1:0] rs,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int extra_waits,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_rdata);
        int stalls = 0;
        drive(we, rs, f3, addr, wd);
        #1;
        chk({tag, "_idle_stall"}, StallMem, 1'b1);
        if (StallMem) stalls++;
        for (int i = 0; i <= extra_waits; i++) begin
            @(negedge clk);
            chk({tag, "_state_busy"}, 32'(dbg_state), 32'(BUSY));
            chk({tag, "_req"}, bus.mem_req, 1'b1);
            chk({tag, "_we"}, bus.mem_we, we);
            chk({tag, "_addr"}, bus.mem_addr, exp_addr);
            chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_wstrb));
            if (we) chk({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
            if (StallMem) stalls++;
            if (i == extra_waits) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd;
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        chk({tag, "_state_done"}, 32'(dbg_state), 32'(DONE));
        chk({tag, "_done_req"}, bus.mem_req, 1'b0);
        chk({tag, "_rdata"}, ReadDataM, exp_rdata);
        chk({tag, "_fault"}, MemFaultM, 1'b0);
        chk({tag, "_done_stall"}, StallMem, 1'b0);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(extra_waits + 2));
        idle_inputs();
        @(negedge clk);
        chk({tag, "_back_idle"}, 32'(dbg_state), 32'(IDLE));
        chk({tag, "_no_reissue"}, bus.mem_req, 1'b0);
        chk({tag, "_rdata_cleared"}, ReadDataM, 32'h0);
    endtask

    // A faulting access: one-cycle fault pulse, no request, no stall; stray mem_ready ignored.
    task automatic fault_case(input string tag, input logic we, input logic [1:0] rs,
                              input logic [2:0] f3, input logic [31:0] addr);
        drive(we, rs, f3, addr, 32'h12345678);
        bus.mem_ready = 1'b1;
        #1;
        chk({tag, "_stall"}, StallMem, 1'b0);
        @(negedge clk);
        chk({tag, "_pulse"}, MemFaultM, 1'b1);
        chk({tag, "_req"}, bus.mem_req, 1'b0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
        idle_inputs();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse_end"}, MemFaultM, 1'b0);
        chk({tag, "_req_end"}, bus.mem_req, 1'b0);
    endtask

    initial begin
        int busy_cycles;
        reset = 1'b1;
        idle_inputs();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_fault", MemFaultM, 1'b0);
        chk("rst_stall", StallMem, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Non-memory instruction never stalls or requests
        drive(1'b0, 2'b00, 3'b010, 32'h0000_0101, 32'hFFFF_FFFF);
        #1;
        chk("alu_stall", StallMem, 1'b0);
        @(negedge clk);
        chk("alu_req", bus.mem_req, 1'b0);
        chk("alu_fault", MemFaultM, 1'b0);
        idle_inputs();
        @(negedge clk);

        access("sw", 1'b1, 2'b00, F3_SW, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0,
               32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        access("lb", 1'b0, RS_LOAD, F3_LB, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0,
               32'h0000_0200, 32'h0, 4'b0000, 32'hFFFF_FF80);
        access("lbu", 1'b0, RS_LOAD, F3_LBU, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0,
               32'h0000_0200, 32'h0, 4'b0000, 32'h0000_0080);
        access("lh", 1'b0, RS_LOAD, F3_LH, 32'h0000_0042, 32'h0, 32'h8001_1234, 0,
               32'h0000_0040, 32'h0, 4'b0000, 32'hFFFF_8001);
        access("lhu", 1'b0, RS_LOAD, F3_LHU, 32'h0000_0042, 32'h0, 32'h8001_1234, 0,
               32'h0000_0040, 32'h0, 4'b0000, 32'h0000_8001);
        access("lw", 1'b0, RS_LOAD, F3_LW, 32'h0000_0100, 32'h0, 32'h1234_5678, 0,
               32'h0000_0100, 32'h0, 4'b0000, 32'h1234_5678);
        access("sh", 1'b1, 2'b00, F3_SH, 32'h0000_0012, 32'h0000_ABCD, 32'h0, 0,
               32'h0000_0010, 32'hABCD_ABCD, 4'b1100, 32'h0);
        access("sb_wait1", 1'b1, 2'b00, F3_SB, 32'h0000_0033, 32'h0000_005A, 32'h0, 1,
               32'h0000_0030, 32'h5A5A_5A5A, 4'b1000, 32'h0);
        access("st_prio", 1'b1, RS_LOAD, F3_SW, 32'h0000_0208, 32'h1122_3344, 32'h0, 0,
               32'h0000_0208, 32'h1122_3344, 4'b1111, 32'h0);
        // Ready arriving on the last allowed BUSY cycle completes normally
        access("ready_at_limit", 1'b0, RS_LOAD, F3_LW, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 3,
               32'h0000_0300, 32'h0, 4'b0000, 32'hCAFE_F00D);

        fault_case("lw_misalign", 1'b0, RS_LOAD, F3_LW, 32'h0000_0101);
        fault_case("lh_misalign", 1'b0, RS_LOAD, F3_LH, 32'h0000_0041);
        fault_case("f3_011", 1'b0, RS_LOAD, 3'b011, 32'h0000_0100);
        fault_case("store_f3_100", 1'b1, 2'b00, 3'b100, 32'h0000_0100);

        // Timeout: LH 0x40 with no ready, MAX_WAIT = 4
        busy_cycles = 0;
        drive(1'b0, RS_LOAD, F3_LH, 32'h0000_0040, 32'h0);
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("to_idle_stall", StallMem, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dbg_state == BUSY && bus.mem_req && StallMem) busy_cycles++;
            chk("to_addr", bus.mem_addr, 32'h0000_0040);
        end
        chk("to_busy_cycles", 32'(busy_cycles), 32'd4);
        @(negedge clk);
        chk("to_state_done", 32'(dbg_state), 32'(DONE));
        chk("to_fault", MemFaultM, 1'b1);
        chk("to_rdata", ReadDataM, 32'h0);
        chk("to_req", bus.mem_req, 1'b0);
        chk("to_stall", StallMem, 1'b0);
        idle_inputs();
        bus.mem_rdata = 32'h0;
        @(negedge clk);
        chk("to_fault_end", MemFaultM, 1'b0);
        chk("to_state_idle", 32'(dbg_state), 32'(IDLE));

        // Reset during the second BUSY cycle
        drive(1'b1, 2'b00, F3_SW, 32'h0000_0080, 32'h0BAD_CAFE);
        @(negedge clk);
        chk("mid_busy1_req", bus.mem_req, 1'b1);
        @(negedge clk);
        chk("mid_busy2_req", bus.mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", bus.mem_req, 1'b0);
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_no_done", 32'(dbg_state), 32'(IDLE));
        chk("mid_req_low", bus.mem_req, 1'b0);
        access("sw_after_rst", 1'b1, 2'b00, F3_SW, 32'h0000_0084, 32'h5555_AAAA, 32'h0, 0,
               32'h0000_0084, 32'h5555_AAAA, 4'b1111, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
